fifo_byte_tx: RTL and testbench

Drain side of the bus FIFO. Pops 32-bit words from the `fifo` read port (`out_fifo`/`empty`/`read_fifo_en`) and transmits each word as four bytes on an 8-bit valid/ready stream toward the downstream link. It is the consumer counterpart of the interface that fills the FIFO. It sustains one byte per cycle with no bubble between back-to-back words.

---
 rtl/fifo_byte_tx.sv | 116 +++++++++++
 tb/tb_fifo_byte_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_tx.sv
// fifo_byte_tx -- drain side of the bus FIFO.
//
// Pops 32-bit words from the FIFO read port and serialises each one as four
// bytes on an 8-bit valid/ready stream. Back-to-back words are sent with no
// idle cycle between them: the next word is popped on the same edge that
// accepts the last byte of the current one.
//
// Parameters:
//   MSB_FIRST    1: byte [31:24] goes first; 0: byte [7:0] goes first
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   out_fifo     FIFO head word (valid while empty = 0)
//   empty        FIFO empty flag
//   read_fifo_en pop strobe to the FIFO (combinational)
//   tx_data      current byte
//   tx_valid     tx_data is valid
//   tx_ready     downstream accepts the byte
//   tx_last      marks the 4th byte of a word
//   busy         a word is held (same as tx_valid)
//   words_sent   count of completed words, wraps at 16 bits
module fifo_byte_tx #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] out_fifo,
  input  logic        empty,
  output logic        read_fifo_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] words_sent
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] hold_reg;
  logic [1:0]  byte_idx_reg;
  logic [15:0] words_sent_reg;

  logic       loaded;
  logic       xfer;
  logic       last_beat;
  logic [7:0] lane [4];

  assign loaded    = (state_reg == SEND);
  assign xfer      = loaded & tx_ready;
  assign last_beat = (byte_idx_reg == 2'd3);

  // Pop when idle, or when the final byte of the held word is being accepted
  // so the next word follows without a bubble. Held low during reset so the
  // FIFO never advances while this block is clearing.
  assign read_fifo_en = ~reset & ~empty & (~loaded | (xfer & last_beat));

  // lane[k] is the byte sent at byte_idx == k.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (MSB_FIRST != 0) begin : g_msb
        assign lane[gi] = hold_reg[31 - 8*gi -: 8];
      end else begin : g_lsb
        assign lane[gi] = hold_reg[8*gi +: 8];
      end
    end
  endgenerate

  // Output byte depends only on registers, never on tx_ready.
  assign tx_data    = lane[byte_idx_reg];
  assign tx_valid   = loaded;
  assign tx_last    = loaded & last_beat;
  assign busy       = loaded;
  assign words_sent = words_sent_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      hold_reg       <= 32'h0;
      byte_idx_reg   <= 2'd0;
      words_sent_reg <= 16'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_fifo_en) begin
            hold_reg     <= out_fifo;
            byte_idx_reg <= 2'd0;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_beat) begin
              words_sent_reg <= words_sent_reg + 16'd1;
              if (read_fifo_en) begin
                // Back-to-back: reload on the same edge as the last accept.
                hold_reg     <= out_fifo;
                byte_idx_reg <= 2'd0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_tx.sv
// Testbench for fifo_byte_tx. Two instances share one FIFO model and one
// downstream: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0). Stimulus pushes
// words into the FIFO model and the expected byte stream into a scoreboard;
// a negedge monitor pops the scoreboard whenever a transfer is presented.
module tb_fifo_byte_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] out_fifo;
  logic        empty;
  logic        tx_ready;

  logic        rden_m, valid_m, last_m, busy_m;
  logic [7:0]  data_m;
  logic [15:0] ws_m;
  logic        rden_l, valid_l, last_l, busy_l;
  logic [7:0]  data_l;
  logic [15:0] ws_l;

  fifo_byte_tx #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .out_fifo(out_fifo), .empty(empty),
    .read_fifo_en(rden_m), .tx_data(data_m), .tx_valid(valid_m),
    .tx_ready(tx_ready), .tx_last(last_m), .busy(busy_m), .words_sent(ws_m)
  );

  fifo_byte_tx #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .out_fifo(out_fifo), .empty(empty),
    .read_fifo_en(rden_l), .tx_data(data_l), .tx_valid(valid_l),
    .tx_ready(tx_ready), .tx_last(last_l), .busy(busy_l), .words_sent(ws_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bm;    // expected byte, MSB-first instance
    logic [7:0] bl;    // expected byte, LSB-first instance
    logic       last;
  } exp_t;

  logic [31:0] fifo_q [$];
  exp_t        exp_q [$];
  int          pop_cycles [$];
  int          xfer_cycles [$];

  int          total = 0;
  int          passed = 0;
  int          cycle = 0;
  int          pops = 0;
  int          completes = 0;
  int          xfer_cnt = 0;
  logic [15:0] ws_model = 16'h0;
  logic        do_pop = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_dm, prev_dl;
  logic        prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
  endtask

  function automatic void update_fifo_outputs();
    empty    = (fifo_q.size() == 0);
    out_fifo = empty ? 32'h0 : fifo_q[0];
  endfunction

  // Advance to just after the next rising edge, applying a pop the monitor
  // saw requested in the preceding cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    do_pop = 1'b0;
    cycle++;
    update_fifo_outputs();
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    fifo_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      e.bm   = w[31 - 8*k -: 8];
      e.bl   = w[8*k +: 8];
      e.last = (k == 3);
      exp_q.push_back(e);
    end
    $display("push word %08h (fifo depth %0d)", w, fifo_q.size());
    update_fifo_outputs();
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !valid_m) return;
      tick();
    end
    total++;
    $display("FAIL drain_timeout actual=%0d_bytes_left required=0", exp_q.size());
  endtask

  task automatic wait_xfers(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (xfer_cnt >= target) return;
      tick();
    end
    total++;
    $display("FAIL xfer_timeout actual=%0d required=%0d", xfer_cnt, target);
  endtask

  // Asserts reset right after an edge; the word in flight (if any) is lost.
  task automatic do_reset();
    exp_t e;
    reset  = 1'b1;
    do_pop = 1'b0;
    #1;
    check("reset_valid_now", {31'b0, valid_m}, 32'h0);
    check("reset_data_now",  {24'b0, data_m},  32'h0);
    check("reset_rden_now",  {31'b0, rden_m},  32'h0);
    check("reset_ws_now",    {16'b0, ws_m},    32'h0);
    if (pops > completes) begin
      do begin
        e = exp_q.pop_front();
      end while (!e.last && exp_q.size() > 0);
    end
    pops      = 0;
    completes = 0;
    ws_model  = 16'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    logic in_flight, xfer, front_last, exp_rden;
    exp_t e;
    if (reset) begin
      do_pop     = 1'b0;
      stall_prev = 1'b0;
      check("rst_valid", {31'b0, valid_m | valid_l}, 32'h0);
      check("rst_rden",  {31'b0, rden_m | rden_l},   32'h0);
      check("rst_data",  {16'b0, data_m, data_l},    32'h0);
    end else begin
      in_flight  = (pops > completes);
      xfer       = valid_m && tx_ready;
      front_last = (exp_q.size() > 0) ? exp_q[0].last : 1'b0;
      exp_rden   = !empty && (!in_flight || (xfer && front_last));
      check("tx_valid",  {31'b0, valid_m}, {31'b0, in_flight});
      check("busy",      {31'b0, busy_m},  {31'b0, in_flight});
      check("tx_valid_lsb", {31'b0, valid_l}, {31'b0, in_flight});
      check("read_fifo_en", {31'b0, rden_m}, {31'b0, exp_rden});
      check("read_fifo_en_lsb", {31'b0, rden_l}, {31'b0, exp_rden});
      check("words_sent", {16'b0, ws_m}, {16'b0, ws_model});
      check("words_sent_lsb", {16'b0, ws_l}, {16'b0, ws_model});
      if (stall_prev && valid_m) begin
        check("stall_data", {16'b0, data_m, data_l}, {16'b0, prev_dm, prev_dl});
        check("stall_last", {31'b0, last_m}, {31'b0, prev_last});
      end
      stall_prev = valid_m && !tx_ready;
      prev_dm    = data_m;
      prev_dl    = data_l;
      prev_last  = last_m;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte actual=%02h required=none", data_m);
        end else begin
          e = exp_q.pop_front();
          $display("byte msb=%02h lsb=%02h last=%0d (exp %02h %02h %0d) cycle %0d",
                   data_m, data_l, last_m, e.bm, e.bl, e.last, cycle);
          check("byte_msb_first", {24'b0, data_m}, {24'b0, e.bm});
          check("byte_lsb_first", {24'b0, data_l}, {24'b0, e.bl});
          check("tx_last", {30'b0, last_m, last_l}, {30'b0, e.last, e.last});
          if (e.last) begin
            completes++;
            ws_model = ws_model + 16'd1;
          end
          xfer_cnt++;
          xfer_cycles.push_back(cycle);
        end
      end
      do_pop = rden_m && !empty;
      if (do_pop) begin
        pops++;
        pop_cycles.push_back(cycle);
      end
    end
  end

  initial begin
    int base, pops_before, pushed;
    reset    = 1'b1;
    tx_ready = 1'b0;
    update_fifo_outputs();
    tick();
    tick();
    reset = 1'b0;

    // Idle with an empty FIFO; tx_ready wiggles but must do nothing.
    for (int i = 0; i < 10; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("idle_data", {24'b0, data_m}, 32'h0);
    check("idle_pops", pop_cycles.size(), 0);

    // Single word.
    tx_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    wait_idle(50);
    check("single_words_sent", {16'b0, ws_m}, 32'd1);
    check("single_pop_pulses", pop_cycles.size(), 1);

    // Three preloaded words, streamed back-to-back.
    do_reset();
    pop_cycles.delete();
    xfer_cycles.delete();
    push_word(32'h00010203);
    push_word(32'h04050607);
    push_word(32'h08090A0B);
    wait_idle(60);
    check("b2b_pop_count", pop_cycles.size(), 3);
    if (pop_cycles.size() == 3) begin
      check("b2b_pop1_offset", pop_cycles[1] - pop_cycles[0], 4);
      check("b2b_pop2_offset", pop_cycles[2] - pop_cycles[0], 8);
    end
    check("b2b_byte_count", xfer_cycles.size(), 12);
    if (xfer_cycles.size() == 12)
      check("b2b_no_gap", xfer_cycles[11] - xfer_cycles[0], 11);
    check("b2b_words_sent", {16'b0, ws_m}, 32'd3);

    // Backpressure while byte 2 is valid, with a second word queued.
    do_reset();
    base = xfer_cnt;
    push_word(32'hCAFEF00D);
    push_word(32'h55AA33CC);
    tx_ready = 1'b1;
    wait_xfers(base + 2, 40);
    tx_ready    = 1'b0;
    pops_before = pops;
    for (int i = 0; i < 3; i++) tick();
    check("stall_no_pop", pops, pops_before);
    check("stall_byte2", {24'b0, data_m}, 32'hF0);
    tx_ready = 1'b1;
    wait_idle(60);
    check("stall_words_sent", {16'b0, ws_m}, 32'd2);

    // Reset after byte 1 of a word with another word queued.
    do_reset();
    base = xfer_cnt;
    push_word(32'hDEADBEEF);
    push_word(32'h12345678);
    tx_ready = 1'b1;
    wait_xfers(base + 2, 40);
    do_reset();
    wait_idle(60);
    check("midreset_words_sent", {16'b0, ws_m}, 32'd1);

    // Random traffic and random backpressure.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 400; i++) begin
      if (pushed < 40 && $urandom_range(0, 2) == 0) begin
        push_word($urandom);
        pushed++;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    while (pushed < 40) begin
      push_word($urandom);
      pushed++;
      tick();
    end
    tx_ready = 1'b1;
    wait_idle(400);
    check("random_words_sent", {16'b0, ws_m}, 32'd40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
